// File: rtl/wb_arb_pkg.sv
// Shared types for the Wishbone memory arbiter: FSM states, master index type
// and the outstanding-counter width helper.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    // Wide enough for up to 16 masters; modules slice down to $clog2(NUM_MASTERS).
    localparam int MAX_IDX_W = 4;
    typedef logic [MAX_IDX_W-1:0] master_idx_t;

    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/wb_arb_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module wb_arb_rr_picker
    import wb_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt,
    output logic             gnt_vld
);

    always_comb begin
        master_idx_t cand;
        gnt     = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        // Walk from the farthest offset back to ptr so the nearest requester wins.
        for (int i = N - 1; i >= 0; i--) begin
            cand = master_idx_t'((int'(ptr) + i) % N);
            if (req[cand[IDX_W-1:0]]) begin
                gnt     = cand[IDX_W-1:0];
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Pipelined-Wishbone N:1 arbiter in front of the shared memory port. Holds the
// grant for a whole cycle and tracks in-flight requests so acks route correctly.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int DATA_WIDTH      = 128,
    parameter int ADDR_WIDTH      = 22,
    parameter int MAX_OUTSTANDING = 20
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [NUM_MASTERS-1:0]                     m_cyc_i,
    input  logic [NUM_MASTERS-1:0]                     m_stb_i,
    input  logic [NUM_MASTERS-1:0]                     m_we_i,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]     m_addr_i,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]   m_sel_i,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]     m_wdata_i,
    output logic [DATA_WIDTH-1:0]                      m_rdata_o,
    output logic [NUM_MASTERS-1:0]                     m_ack_o,
    output logic [NUM_MASTERS-1:0]                     m_err_o,
    output logic [NUM_MASTERS-1:0]                     m_rty_o,
    output logic [NUM_MASTERS-1:0]                     m_stall_o,
    output logic                                       s_cyc_o,
    output logic                                       s_stb_o,
    output logic                                       s_we_o,
    output logic [ADDR_WIDTH-1:0]                      s_addr_o,
    output logic [DATA_WIDTH/8-1:0]                    s_sel_o,
    output logic [DATA_WIDTH-1:0]                      s_wdata_o,
    input  logic [DATA_WIDTH-1:0]                      s_rdata_i,
    input  logic                                       s_ack_i,
    input  logic                                       s_err_i,
    input  logic                                       s_rty_i,
    input  logic                                       s_stall_i,
    output logic [$clog2(NUM_MASTERS)-1:0]             owner_o,
    output logic                                       busy_o,
    output logic                                       proto_err_o
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = cnt_width(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    arb_state_e       state, state_nxt;
    logic [IDX_W-1:0] owner, owner_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] owner_inc;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             proto_err, proto_err_nxt;
    logic             owner_cyc;
    logic             resp;
    logic             resp_valid;
    logic             accept;

    wb_arb_rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (m_cyc_i),
        .ptr     (ptr),
        .gnt     (pick_idx),
        .gnt_vld (pick_vld)
    );

    assign owner_inc   = (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);
    assign owner_cyc   = m_cyc_i[owner];
    assign resp        = s_ack_i | s_err_i | s_rty_i;
    // A response with nothing in flight is never forwarded or counted.
    assign resp_valid  = resp & (cnt != '0);
    assign m_rdata_o   = s_rdata_i;
    assign owner_o     = owner;
    assign busy_o      = (state != IDLE);
    assign proto_err_o = proto_err;

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        ptr_nxt       = ptr;
        proto_err_nxt = proto_err | (resp & (cnt == '0));
        s_cyc_o       = 1'b0;
        s_stb_o       = 1'b0;
        s_we_o        = 1'b0;
        s_addr_o      = '0;
        s_sel_o       = '0;
        s_wdata_o     = '0;
        m_ack_o       = '0;
        m_err_o       = '0;
        m_rty_o       = '0;
        m_stall_o     = '1;

        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = OWNED;
                    owner_nxt = pick_idx;
                end
            end
            OWNED: begin
                s_cyc_o          = owner_cyc;
                s_stb_o          = owner_cyc & m_stb_i[owner] & (cnt < CNT_MAX);
                s_we_o           = m_we_i[owner];
                s_addr_o         = m_addr_i[owner];
                s_sel_o          = m_sel_i[owner];
                s_wdata_o        = m_wdata_i[owner];
                m_stall_o[owner] = s_stall_i | (cnt == CNT_MAX);
                m_ack_o[owner]   = s_ack_i & resp_valid;
                m_err_o[owner]   = s_err_i & resp_valid;
                m_rty_o[owner]   = s_rty_i & resp_valid;
                if (!owner_cyc) begin
                    if (cnt == '0) begin
                        state_nxt = IDLE;
                        ptr_nxt   = owner_inc;
                    end else begin
                        // Owner left with responses pending: swallow them in DRAIN.
                        state_nxt     = DRAIN;
                        proto_err_nxt = 1'b1;
                    end
                end
            end
            DRAIN: begin
                s_cyc_o = 1'b1;
                if ((cnt == '0) || ((cnt == CNT_W'(1)) && resp)) begin
                    state_nxt = IDLE;
                    ptr_nxt   = owner_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase

        accept = s_stb_o & ~s_stall_i;
        case ({accept, resp_valid})
            2'b10:   cnt_nxt = cnt + CNT_W'(1);
            2'b01:   cnt_nxt = cnt - CNT_W'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '0;
            cnt       <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            proto_err <= proto_err_nxt;
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter with a transaction-level reference model.
`timescale 1ns/1ps
module tb_wb_mem_arbiter;

    localparam int NM = 2;
    localparam int DW = 32;
    localparam int AW = 22;
    localparam int MO = 4;

    logic                     clk = 1'b0;
    logic                     rst_i = 1'b1;
    logic [NM-1:0]            m_cyc, m_stb, m_we;
    logic [NM-1:0][AW-1:0]    m_addr;
    logic [NM-1:0][DW/8-1:0]  m_sel;
    logic [NM-1:0][DW-1:0]    m_wdata;
    logic [DW-1:0]            m_rdata_o;
    logic [NM-1:0]            m_ack_o, m_err_o, m_rty_o, m_stall_o;
    logic                     s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]            s_addr_o;
    logic [DW/8-1:0]          s_sel_o;
    logic [DW-1:0]            s_wdata_o;
    logic [DW-1:0]            s_rdata_i;
    logic                     s_ack_i, s_err_i, s_rty_i, s_stall_i;
    logic [0:0]               owner_o;
    logic                     busy_o, proto_err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_mem_arbiter #(
        .NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_addr_i(m_addr), .m_sel_i(m_sel), .m_wdata_i(m_wdata),
        .m_rdata_o(m_rdata_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .m_rty_o(m_rty_o), .m_stall_o(m_stall_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_addr_o(s_addr_o), .s_sel_o(s_sel_o), .s_wdata_o(s_wdata_o),
        .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .s_rty_i(s_rty_i), .s_stall_i(s_stall_i),
        .owner_o(owner_o), .busy_o(busy_o), .proto_err_o(proto_err_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return 32'hA500_0000 | DW'(a);
    endfunction

    function automatic logic [DW-1:0] wd(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | DW'(a);
    endfunction

    // ---------------- reference model (transaction level) ----------------
    bit md_owned, md_drain, md_perr;
    int md_own, md_pend, md_ptr;

    task automatic md_reset();
        md_owned = 0; md_drain = 0; md_perr = 0;
        md_own = 0; md_pend = 0; md_ptr = 0;
    endtask

    function automatic bit exp_stb();
        return md_owned && m_cyc[md_own] && m_stb[md_own] && (md_pend < MO);
    endfunction

    task automatic md_step();
        bit rsp, acc;
        int old;
        rsp = s_ack_i || s_err_i || s_rty_i;
        acc = exp_stb() && !s_stall_i;
        old = md_pend;
        if (!md_owned && !md_drain) begin
            if (rsp) md_perr = 1;
            for (int k = 0; k < NM; k++) begin
                if (m_cyc[(md_ptr + k) % NM]) begin
                    md_own = (md_ptr + k) % NM;
                    md_owned = 1;
                    break;
                end
            end
        end else if (md_owned) begin
            if (rsp) begin
                if (old == 0) md_perr = 1;
                else md_pend--;
            end
            if (acc) md_pend++;
            if (!m_cyc[md_own]) begin
                md_owned = 0;
                if (old == 0) md_ptr = (md_own + 1) % NM;
                else begin md_drain = 1; md_perr = 1; end
            end
        end else begin
            if (rsp) begin
                if (md_pend > 0) md_pend--;
                else md_perr = 1;
            end
            if (md_pend == 0) begin
                md_drain = 0;
                md_ptr = (md_own + 1) % NM;
            end
        end
    endtask

    initial begin
        md_reset();
        forever begin
            @(posedge clk or posedge rst_i);
            if (rst_i) md_reset();
            else md_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    int max_cnt = 0;
    bit ack1_seen = 0;
    int err1_cnt = 0;

    initial begin
        logic [NM-1:0] ea, ee, er, es;
        forever begin
            @(negedge clk);
            #2;
            ea = '0; ee = '0; er = '0; es = '1;
            if (md_owned) begin
                es[md_own] = s_stall_i || (md_pend == MO);
                if (md_pend > 0) begin
                    ea[md_own] = s_ack_i; ee[md_own] = s_err_i; er[md_own] = s_rty_i;
                end
            end
            chk("s_cyc", s_cyc_o, md_owned ? m_cyc[md_own] : md_drain);
            chk("s_stb", s_stb_o, exp_stb());
            chk("s_we", s_we_o, md_owned ? m_we[md_own] : 1'b0);
            chk("s_addr", s_addr_o, md_owned ? m_addr[md_own] : '0);
            chk("s_sel", s_sel_o, md_owned ? m_sel[md_own] : '0);
            chk("s_wdata", s_wdata_o, md_owned ? m_wdata[md_own] : '0);
            chk("m_ack", m_ack_o, ea);
            chk("m_err", m_err_o, ee);
            chk("m_rty", m_rty_o, er);
            chk("m_stall", m_stall_o, es);
            chk("m_rdata", m_rdata_o, s_rdata_i);
            chk("owner", owner_o, 64'(md_own));
            chk("busy", busy_o, md_owned || md_drain);
            chk("proto_err", proto_err_o, md_perr);
            chk("cnt", dut.cnt, 64'(md_pend));
            chk("ptr", dut.ptr, 64'(md_ptr));
            if (int'(dut.cnt) > max_cnt) max_cnt = int'(dut.cnt);
            if (m_ack_o[1]) ack1_seen = 1;
            if (m_err_o[1]) err1_cnt++;
        end
    end

    // ---------------- slave: queued acks, optional alternating stall ----------------
    logic [AW-1:0] sq[$];
    bit ack_en = 0, stall_en = 0, tog = 0;

    initial begin
        logic [AW-1:0] a;
        s_ack_i = 0; s_err_i = 0; s_rty_i = 0; s_stall_i = 0; s_rdata_i = '0;
        forever begin
            @(negedge clk);
            s_ack_i = 0; s_err_i = 0; s_rdata_i = '0;
            tog = ~tog;
            s_stall_i = stall_en & tog;
            if (ack_en && sq.size() > 0) begin
                a = sq.pop_front();
                if (a[5]) s_err_i = 1;
                else begin s_ack_i = 1; s_rdata_i = mem_rd(a); end
            end
            #3;
            if (!rst_i && s_stb_o && !s_stall_i) sq.push_back(s_addr_o);
        end
    end

    // ---------------- master helpers ----------------
    logic [DW-1:0] rd_q[$];
    int first_stall = -1;

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1; m_cyc = '0; m_stb = '0; ack_en = 0;
        @(negedge clk);
        sq.delete();
        rst_i = 0;
    endtask

    task automatic stream(input int m, input logic [AW-1:0] base, input int n,
                          input bit we, input int budget);
        int issued, acks, cyc_n;
        issued = 0; acks = 0; cyc_n = 0;
        @(negedge clk);
        m_cyc[m] = 1; m_stb[m] = 1; m_we[m] = we; m_sel[m] = '1;
        m_addr[m] = base; m_wdata[m] = wd(base);
        forever begin
            #3;
            if (m_stb[m] && !m_stall_o[m]) issued++;
            else if (m_stb[m] && m_stall_o[m] && issued > 0 && first_stall < 0) first_stall = issued;
            if (m_ack_o[m] || m_err_o[m] || m_rty_o[m]) begin
                acks++;
                rd_q.push_back(m_rdata_o);
            end
            @(negedge clk);
            cyc_n++;
            if (acks >= n || cyc_n > budget) begin
                m_cyc[m] = 0; m_stb[m] = 0;
                break;
            end
            if (issued >= n) m_stb[m] = 0;
            else begin
                m_addr[m] = base + AW'(issued);
                m_wdata[m] = wd(base + AW'(issued));
            end
        end
        chk("stream_acks", acks, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fwd;
        m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_sel = '0; m_wdata = '0;
        // Reset state
        @(negedge clk); #3;
        chk("rst_stall", m_stall_o, 2'b11);
        chk("rst_busy", busy_o, 0);
        chk("rst_perr", proto_err_o, 0);
        chk("rst_scyc", s_cyc_o, 0);
        @(negedge clk); rst_i = 0;

        // Single master: 4 pipelined reads with an alternating slave stall
        ack_en = 1; stall_en = 1; rd_q.delete();
        stream(0, 22'h10, 4, 0, 60);
        stall_en = 0;
        chk("single_cnt", rd_q.size(), 4);
        for (int k = 0; k < 4 && k < rd_q.size(); k++)
            chk("single_data", rd_q[k], 32'hA500_0010 + 32'(k));
        chk("single_ack1", ack1_seen, 0);

        // Contention with pointer at 0
        do_reset();
        @(negedge clk); m_cyc = 2'b11; #3;
        chk("cont_idle", busy_o, 0);
        @(negedge clk); #3;
        chk("cont_own0", owner_o, 0);
        chk("cont_stall0", m_stall_o, 2'b10);
        @(negedge clk); m_cyc[0] = 0;
        @(negedge clk); #3;
        chk("cont_gap", busy_o, 0);
        @(negedge clk); #3;
        chk("cont_own1", owner_o, 1);
        chk("cont_stall1", m_stall_o, 2'b01);
        @(negedge clk); m_cyc[1] = 0;
        @(negedge clk); #3;
        chk("cont_ptr", dut.ptr, 0);
        chk("cont_end", busy_o, 0);

        // Outstanding limit: 8 writes, acks held back at first
        do_reset();
        first_stall = -1; max_cnt = 0; rd_q.delete();
        fork
            stream(0, 22'h100, 8, 1, 80);
            begin
                repeat (12) @(negedge clk);
                #3;
                chk("lim_stall", m_stall_o[0], 1);
                chk("lim_first", first_stall, 4);
                chk("lim_cnt", dut.cnt, 4);
                ack_en = 1;
            end
        join
        chk("lim_acks", rd_q.size(), 8);
        chk("lim_max", max_cnt, 4);

        // Accept and ack in the same cycle at cnt=2
        do_reset();
        @(negedge clk); m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 0; m_addr[0] = 22'h50;
        @(negedge clk);
        @(negedge clk); #3; ack_en = 1;
        @(negedge clk); #3; ack_en = 0;
        chk("sim_cnt_pre", dut.cnt, 2);
        chk("sim_both", {m_ack_o[0], m_stall_o[0]}, 2'b10);
        @(negedge clk); m_stb[0] = 0; #3;
        chk("sim_cnt", dut.cnt, 2);
        ack_en = 1;
        for (int i = 0; i < 10 && dut.cnt != 0; i++) begin @(negedge clk); #3; end
        chk("sim_drained", dut.cnt, 0);
        @(negedge clk); m_cyc[0] = 0;
        @(negedge clk); #3;
        chk("sim_idle", busy_o, 0);

        // Abandoned cycle with 3 outstanding
        do_reset();
        @(negedge clk); m_cyc[0] = 1; m_stb[0] = 1; m_addr[0] = 22'h44;
        repeat (3) @(negedge clk);
        @(negedge clk); m_cyc[0] = 0; m_stb[0] = 0;
        @(negedge clk); #3;
        chk("ab_busy", busy_o, 1);
        chk("ab_scyc", s_cyc_o, 1);
        chk("ab_sstb", s_stb_o, 0);
        chk("ab_stall", m_stall_o, 2'b11);
        chk("ab_perr", proto_err_o, 1);
        chk("ab_cnt", dut.cnt, 3);
        ack_en = 1; fwd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #3;
            if (m_ack_o != 0 || m_err_o != 0 || m_rty_o != 0) fwd = 1;
            if (!busy_o) break;
        end
        chk("ab_fwd", fwd, 0);
        chk("ab_idle", busy_o, 0);
        chk("ab_perr_end", proto_err_o, 1);

        // Reset asserted with 2 outstanding
        do_reset();
        @(negedge clk); m_cyc[0] = 1; m_stb[0] = 1; m_addr[0] = 22'h48;
        repeat (2) @(negedge clk);
        @(negedge clk); m_stb[0] = 0; #3;
        chk("mr_cnt", dut.cnt, 2);
        @(negedge clk); rst_i = 1; m_cyc = '0; #3;
        chk("mr_stall", m_stall_o, 2'b11);
        chk("mr_busy", busy_o, 0);
        chk("mr_cnt0", dut.cnt, 0);
        chk("mr_perr0", proto_err_o, 0);
        @(negedge clk); rst_i = 0; #3; ack_en = 1;
        repeat (3) @(negedge clk);
        #3;
        chk("mr_perr", proto_err_o, 1);
        ack_en = 0;

        // Error response routed to master 1
        do_reset();
        err1_cnt = 0; ack_en = 1;
        stream(1, 22'h20, 1, 0, 20);
        chk("err_m1", err1_cnt, 1);
        @(negedge clk); #3;
        chk("err_idle", busy_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
